// File: rtl/exec_datapath_pkg.sv
// Shared encodings for the decoder -> execute interface: source selects and
// active-low load-enable bit positions.
package exec_datapath_pkg;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;
  localparam int LD_W   = 4;

  typedef logic [LD_W-1:0] ld_t;

endpackage

// File: rtl/exec_datapath_in_sync.sv
// Multi-flop synchronizer for the asynchronous switch input; stage 0 samples
// the pin, the last stage is the only one the datapath may consume.
module exec_datapath_in_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] sync_q, sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/exec_datapath.sv
// Execute/register stage: selects a source, adds the immediate, and loads
// A/B/OUT/PC from the shared result under active-low enables from the decoder.
module exec_datapath
  import exec_datapath_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int PC_W        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        sel,
  input  logic [LD_W-1:0]   ld,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] out_port,
  output logic [PC_W-1:0]   pc,
  output logic              c
);

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              c_q, c_d;
  logic [DATA_W-1:0] in_sync, src, res;
  logic [DATA_W:0]   sum;
  logic [PC_W-1:0]   res_pc;
  ld_t               ld_n;

  exec_datapath_in_sync #(.W(DATA_W), .STAGES(SYNC_STAGES)) u_in_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_port),
    .q     (in_sync)
  );

  assign ld_n = ld;

  always_comb begin
    src = '0;
    case (sel)
      SEL_A:   src = a_q;
      SEL_B:   src = b_q;
      SEL_IN:  src = in_sync;
      default: src = '0;
    endcase
    sum    = {1'b0, src} + {1'b0, imm};
    res    = sum[DATA_W-1:0];
    res_pc = PC_W'(res);
  end

  // Loads compare against 0 so an unknown enable bit falls to the hold path.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    pc_d  = pc_q;
    c_d   = c_q;
    if (en) begin
      if (ld_n[LD_A]   == 1'b0) a_d   = res;
      if (ld_n[LD_B]   == 1'b0) b_d   = res;
      if (ld_n[LD_OUT] == 1'b0) out_d = res;
      if (ld_n[LD_PC]  == 1'b0) pc_d  = res_pc;
      else                      pc_d  = pc_q + PC_W'(1);
      c_d = sum[DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      pc_q  <= '0;
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      pc_q  <= pc_d;
      c_q   <= c_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign out_port = out_q;
  assign pc       = pc_q;
  assign c        = c_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Directed bench for exec_datapath: integer-level reference model compared on
// every falling edge, plus hand-computed literal checkpoints.
module tb_exec_datapath;
  localparam int DW = 4;
  localparam int PW = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    sel = 2'b11;
  logic [3:0]    ld = 4'hF;
  logic [DW-1:0] imm = '0;
  logic [DW-1:0] in_port = '0;
  logic [DW-1:0] a, b, out_port;
  logic [PW-1:0] pc;
  logic          c;

  int errors = 0;
  int checks = 0;

  exec_datapath #(.DATA_W(DW), .PC_W(PW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .ld(ld), .imm(imm),
    .in_port(in_port), .a(a), .b(b), .out_port(out_port), .pc(pc), .c(c)
  );

  always #5 clk = ~clk;

  // Reference model in plain integers; the input pipeline is a history queue.
  int m_a, m_b, m_out, m_pc, m_c;
  int hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_c = 0;
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(0);
    end else begin
      int s, total, r;
      if (en) begin
        case (sel)
          2'b00:   s = m_a;
          2'b01:   s = m_b;
          2'b10:   s = hist[0];
          default: s = 0;
        endcase
        total = s + int'(imm);
        r     = total % (1 << DW);
        if (ld[0] == 1'b0) m_a = r;
        if (ld[1] == 1'b0) m_b = r;
        if (ld[2] == 1'b0) m_out = r;
        if (ld[3] == 1'b0) m_pc = r % (1 << PW);
        else               m_pc = (m_pc + 1) % (1 << PW);
        m_c = (total >= (1 << DW)) ? 1 : 0;
      end
      hist.push_back(int'(in_port));
      void'(hist.pop_front());
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_a",   int'(a),        m_a);
      chk("model_b",   int'(b),        m_b);
      chk("model_out", int'(out_port), m_out);
      chk("model_pc",  int'(pc),       m_pc);
      chk("model_c",   int'(c),        m_c);
    end
  end

  task automatic step(input logic e, input logic [1:0] s, input logic [3:0] l,
                      input logic [DW-1:0] im);
    en = e; sel = s; ld = l; imm = im;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_a", int'(a), 0);
    chk("rst_b", int'(b), 0);
    chk("rst_out", int'(out_port), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_c", int'(c), 0);
    rst_n = 1'b1;

    // First load after reset, then asynchronous mid-cycle reset.
    step(1'b1, 2'b11, 4'b1110, 4'd5);
    chk("t1_a", int'(a), 5);
    chk("t1_pc", int'(pc), 1);
    chk("t1_c", int'(c), 0);
    en = 1'b0; ld = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("async_a", int'(a), 0);
    chk("async_pc", int'(pc), 0);
    chk("async_c", int'(c), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Carry out of the adder, then carry clears on a no-load cycle.
    step(1'b1, 2'b11, 4'b1110, 4'd12);
    chk("t2_a12", int'(a), 12);
    step(1'b1, 2'b00, 4'b1110, 4'd7);
    chk("t2_a", int'(a), 3);
    chk("t2_c", int'(c), 1);
    step(1'b1, 2'b00, 4'b1111, 4'd0);
    chk("t2_c0", int'(c), 0);
    chk("t2_pc", int'(pc), 3);

    // PC wrap and jump.
    step(1'b1, 2'b11, 4'b0111, 4'd14);
    chk("t3_pc14", int'(pc), 14);
    step(1'b1, 2'b00, 4'b1111, 4'd0);
    chk("t3_pc15", int'(pc), 15);
    step(1'b1, 2'b00, 4'b1111, 4'd0);
    chk("t3_wrap", int'(pc), 0);
    step(1'b1, 2'b11, 4'b0111, 4'd9);
    chk("t3_jmp", int'(pc), 9);
    chk("t3_a", int'(a), 3);
    chk("t3_b", int'(b), 0);
    chk("t3_out", int'(out_port), 0);

    // Input synchronizer latency.
    in_port = 4'hA;
    step(1'b1, 2'b11, 4'b1111, 4'd0);
    step(1'b1, 2'b10, 4'b1101, 4'd0);
    chk("sync_early", int'(b), 0);
    step(1'b1, 2'b10, 4'b1101, 4'd0);
    chk("sync_late", int'(b), 10);
    chk("sync_pc", int'(pc), 12);

    // Hold while en is low, then load all at once.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b11, 4'b0000, 4'd6);
      chk("hold_a", int'(a), 3);
      chk("hold_b", int'(b), 10);
      chk("hold_pc", int'(pc), 12);
    end
    step(1'b1, 2'b11, 4'b0000, 4'd6);
    chk("all_a", int'(a), 6);
    chk("all_b", int'(b), 6);
    chk("all_out", int'(out_port), 6);
    chk("all_pc", int'(pc), 6);

    // B routed to OUT.
    step(1'b1, 2'b11, 4'b1101, 4'd4);
    step(1'b1, 2'b01, 4'b1011, 4'd0);
    chk("bout_out", int'(out_port), 4);
    chk("bout_b", int'(b), 4);
    chk("bout_c", int'(c), 0);
    step(1'b1, 2'b01, 4'b1111, 4'd15);
    chk("bcy_c", int'(c), 1);
    chk("bcy_out", int'(out_port), 4);

    in_port = 4'h3;
    repeat (3) step(1'b1, 2'b10, 4'b1110, 4'd1);
    chk("in3_a", int'(a), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
